led_text: RTL and testbench

LED_TEXT -- requirements
Module: led_text

---
 rtl/led_text_pkg.sv | 22 ++
 rtl/led_text_tick.sv | 29 ++
 rtl/led_text.sv | 84 ++++++++
 tb/tb_led_text.sv | 108 ++++++++++
 4 files changed

// File: rtl/led_text_pkg.sv
// Shared types and pattern constants for the LED text/pattern walker.
package led_text_pkg;

  typedef enum logic [1:0] {
    S_LEFT  = 2'd0,
    S_RIGHT = 2'd1,
    S_BLINK = 2'd2
  } state_e;

  localparam logic [3:0] LED_RESET       = 4'b0001;
  localparam logic [3:0] LED_RIGHT_START = 4'b0100;
  localparam logic [3:0] LED_ALL_ON      = 4'b1111;
  localparam logic [3:0] LED_LEFT_END    = 4'b1000;
  localparam logic [3:0] LED_RIGHT_END   = 4'b0001;
  localparam logic [1:0] BLINK_LAST      = 2'd3;

  // Prescaler width: enough bits to hold CNT_MAX-1, never less than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_text_tick.sv
// Prescaler: free-running 0..CNT_MAX-1 counter with a one-cycle tick on the last count.
module led_text_tick
  import led_text_pkg::*;
#(
  parameter int unsigned CNT_MAX = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,   // active-high despite the name
  output logic tick
);

  localparam int unsigned     CW   = cnt_w(CNT_MAX);
  localparam logic [CW-1:0]   LAST = CW'(CNT_MAX - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Tick on the terminal count; wrap to zero on the same cycle.
  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  // Counter register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_text.sv
// LED pattern walker: shift left, shift right, blink twice, repeat; advances once per tick.
module led_text
  import led_text_pkg::*;
#(
  parameter int unsigned CNT_MAX = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,   // active-high despite the name
  output logic [3:0] led
);

  logic       tick;
  state_e     state_q, state_d;
  logic [3:0] led_q, led_d;
  logic [1:0] bc_q, bc_d;

  led_text_tick #(.CNT_MAX(CNT_MAX)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // State, pattern and blink-count registers; everything holds between ticks.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= S_LEFT;
      led_q   <= LED_RESET;
      bc_q    <= '0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      bc_q    <= bc_d;
    end
  end

  // Next-state: one pattern step per tick; illegal encodings restart the pattern.
  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    bc_d    = bc_q;
    if (tick) begin
      case (state_q)
        S_LEFT: begin
          if (led_q == LED_LEFT_END) begin
            state_d = S_RIGHT;
            led_d   = LED_RIGHT_START;
          end else begin
            led_d = led_q << 1;
          end
        end
        S_RIGHT: begin
          if (led_q == LED_RIGHT_END) begin
            state_d = S_BLINK;
            led_d   = LED_ALL_ON;
            bc_d    = '0;
          end else begin
            led_d = led_q >> 1;
          end
        end
        S_BLINK: begin
          if (bc_q == BLINK_LAST) begin
            state_d = S_LEFT;
            led_d   = LED_RESET;
            bc_d    = '0;
          end else begin
            led_d = ~led_q;
            bc_d  = bc_q + 2'd1;
          end
        end
        default: begin
          state_d = S_LEFT;
          led_d   = LED_RESET;
          bc_d    = '0;
        end
      endcase
    end
  end

  // Output: drive the LEDs straight from the pattern register.
  always_comb begin
    led = led_q;
  end

endmodule

// File: tb/tb_led_text.sv
// Bench for led_text: timeline model (ticks = edges / CNT_MAX, pattern table of 11 steps).
module tb_led_text;

  logic       clk;
  logic       rst, rst1;
  logic [3:0] led, led1;

  int checks = 0;
  int errors = 0;
  int k      = 0;   // rising edges since last release of dut

  logic [3:0] seq [11] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010,
                           4'b0001, 4'b1111, 4'b0000, 4'b1111, 4'b0000};

  led_text #(.CNT_MAX(10)) dut  (.clk(clk), .rst_n(rst),  .led(led));
  led_text #(.CNT_MAX(1))  dut1 (.clk(clk), .rst_n(rst1), .led(led1));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (k=%0d, t=%0t)", tag, got, exp, k, $time);
    end
  endtask

  function automatic logic [3:0] exp_led(input int edges, input int n);
    return seq[(edges / n) % 11];
  endfunction

  // Advance n cycles, checking the pattern at every falling edge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      chk("seq", led, exp_led(k, 10));
    end
  endtask

  // Assert reset asynchronously mid-cycle, check it takes effect before the next edge,
  // hold for a number of cycles, then release on a falling edge.
  task automatic mid_reset(input string tag, input int hold);
    #($urandom_range(1, 8));
    rst = 1'b1;
    #1;
    chk(tag, led, 4'b0001);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_hold", led, 4'b0001);
    end
    rst = 1'b0;
    k   = 0;
  endtask

  initial begin
    rst  = 1'b1;
    rst1 = 1'b1;
    #5;
    chk("rst_async0", led, 4'b0001);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("reset", led, 4'b0001);
    end
    rst = 1'b0;
    k   = 0;

    // Hold for 9 edges, first change at edge 10, then a long run of 100 ticks.
    run(1000);
    chk("tick100", led, 4'b0010);

    // Reset while blinking with all LEDs off.
    for (int i = 0; i < 200; i++) begin
      if (((k / 10) % 11) == 8 || ((k / 10) % 11) == 10) break;
      run(1);
    end
    chk("blink_off", led, 4'b0000);
    mid_reset("blink_rst", 3);
    run(9);
    chk("restart_hold", led, 4'b0001);
    run(1);
    chk("restart_first", led, 4'b0010);
    run(110);

    // Randomly timed resets of random length.
    for (int r = 0; r < 6; r++) begin
      run($urandom_range(0, 250));
      mid_reset("rand_rst", $urandom_range(1, 4));
      run($urandom_range(10, 120));
    end

    // CNT_MAX=1: one pattern step per clock.
    chk("cnt1_rst", led1, 4'b0001);
    rst1 = 1'b0;
    for (int j = 1; j <= 60; j++) begin
      @(posedge clk);
      @(negedge clk);
      chk("cnt1_seq", led1, seq[j % 11]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
